// File: rtl/job_seq_pkg.sv
// Shared definitions for the job sequencer.
//   - state_e      : sequencer FSM states
//   - Prog*        : program codes carried on req_prog / rsp_prog
//   - *OpBase/*ResBase, *OpBytes/*ResBytes : per-program operand and result
//                    locations in the attached data memory
//   - helper functions mapping a program code to its memory layout and
//     selecting operand bytes most-significant first
package job_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StStart,
    StWait,
    StRead,
    StResp
  } state_e;

  localparam logic [1:0] ProgIllegal = 2'd0;
  localparam logic [1:0] ProgRecip   = 2'd1;
  localparam logic [1:0] ProgDiv     = 2'd2;
  localparam logic [1:0] ProgSqrt    = 2'd3;

  // Operand bytes are written starting at the base, MSB first.
  localparam logic [7:0] RecipOpBase  = 8'd8;
  localparam logic [7:0] DivOpBase    = 8'd0;
  localparam logic [7:0] SqrtOpBase   = 8'd13;
  localparam logic [1:0] RecipOpBytes = 2'd2;
  localparam logic [1:0] DivOpBytes   = 2'd3;
  localparam logic [1:0] SqrtOpBytes  = 2'd2;

  // Result bytes are read starting at the base, MSB first.
  localparam logic [7:0] RecipResBase  = 8'd10;
  localparam logic [7:0] DivResBase    = 8'd4;
  localparam logic [7:0] SqrtResBase   = 8'd15;
  localparam logic [1:0] RecipResBytes = 2'd2;
  localparam logic [1:0] DivResBytes   = 2'd3;
  localparam logic [1:0] SqrtResBytes  = 2'd1;

  // Result reported for an illegal program or a timed-out job.
  localparam logic [23:0] ErrResult = 24'hFFFFFF;

  function automatic logic [7:0] op_base(input logic [1:0] prog);
    logic [7:0] base;
    case (prog)
      ProgRecip: base = RecipOpBase;
      ProgDiv:   base = DivOpBase;
      ProgSqrt:  base = SqrtOpBase;
      default:   base = 8'd0;
    endcase
    return base;
  endfunction

  function automatic logic [1:0] op_bytes(input logic [1:0] prog);
    logic [1:0] n;
    case (prog)
      ProgRecip: n = RecipOpBytes;
      ProgDiv:   n = DivOpBytes;
      ProgSqrt:  n = SqrtOpBytes;
      default:   n = 2'd1;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] res_base(input logic [1:0] prog);
    logic [7:0] base;
    case (prog)
      ProgRecip: base = RecipResBase;
      ProgDiv:   base = DivResBase;
      ProgSqrt:  base = SqrtResBase;
      default:   base = 8'd0;
    endcase
    return base;
  endfunction

  function automatic logic [1:0] res_bytes(input logic [1:0] prog);
    logic [1:0] n;
    case (prog)
      ProgRecip: n = RecipResBytes;
      ProgDiv:   n = DivResBytes;
      ProgSqrt:  n = SqrtResBytes;
      default:   n = 2'd1;
    endcase
    return n;
  endfunction

  // rem = number of bytes still to follow the selected one; rem 0 is the LSB.
  function automatic logic [7:0] op_byte(input logic [23:0] op, input logic [1:0] rem);
    logic [7:0] b;
    case (rem)
      2'd0:    b = op[7:0];
      2'd1:    b = op[15:8];
      default: b = op[23:16];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/job_seq_timer.sv
// Done-wait timeout counter for the job sequencer.
//   clk_i     : system clock
//   rst_ni    : asynchronous active-low reset
//   clear_i   : synchronously returns the count to zero
//   en_i      : count one cycle of waiting
//   expire_o  : high during the TIMEOUT_CYCLES-th enabled cycle after a clear
module job_seq_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // The count sits at LastCnt on the final permitted waiting cycle.
  assign expire_o = en_i && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/job_sequencer.sv
// Job sequencer: accepts a program request, writes its operand bytes into the
// compute engine's data memory, pulses start, waits for done (with timeout),
// reads the result bytes back and holds a response until it is consumed.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake; req_prog program, req_op operands
//   mem_we/addr/wdata     : byte write port into the data memory
//   mem_rdata             : combinational read data for mem_addr
//   start / done          : launch pulse to and completion from the engine
//   rsp_valid/rsp_ready   : response handshake; rsp_prog, rsp_result, rsp_err
module job_sequencer
  import job_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned START_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_prog,
  input  logic [23:0] req_op,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        start,
  input  logic        done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_prog,
  output logic [23:0] rsp_result,
  output logic        rsp_err
);

  localparam int unsigned StartW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [StartW-1:0] StartLast = StartW'(START_CYCLES - 1);

  state_e            state_q;
  logic [1:0]        prog_q;
  logic [23:0]       op_q;
  logic [1:0]        idx_q;
  logic [StartW-1:0] scnt_q;
  logic              req_ready_q;
  logic              mem_we_q;
  logic [7:0]        mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              start_q;
  logic              rsp_valid_q;
  logic [23:0]       result_q;
  logic              err_q;

  logic              in_wait;
  logic              timer_expire;

  assign in_wait = (state_q == StWait);

  job_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (!in_wait),
    .en_i    (in_wait),
    .expire_o(timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      prog_q      <= '0;
      op_q        <= '0;
      idx_q       <= '0;
      scnt_q      <= '0;
      req_ready_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            prog_q      <= req_prog;
            op_q        <= req_op;
            idx_q       <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            if (req_prog == ProgIllegal) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              err_q       <= 1'b1;
              result_q    <= ErrResult;
            end else begin
              // First operand byte is presented the cycle after acceptance.
              state_q     <= StWrite;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= op_base(req_prog);
              mem_wdata_q <= op_byte(req_op, op_bytes(req_prog) - 2'd1);
            end
          end
        end

        StWrite: begin
          if (idx_q == op_bytes(prog_q) - 2'd1) begin
            state_q     <= StStart;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            start_q     <= 1'b1;
            scnt_q      <= '0;
          end else begin
            idx_q       <= idx_q + 2'd1;
            mem_addr_q  <= mem_addr_q + 8'd1;
            mem_wdata_q <= op_byte(op_q, op_bytes(prog_q) - 2'd2 - idx_q);
          end
        end

        StStart: begin
          if (scnt_q == StartLast) begin
            state_q <= StWait;
            start_q <= 1'b0;
            scnt_q  <= '0;
          end else begin
            scnt_q <= scnt_q + 1'b1;
          end
        end

        StWait: begin
          // done wins over an expiry landing in the same cycle.
          if (done) begin
            state_q    <= StRead;
            idx_q      <= '0;
            mem_addr_q <= res_base(prog_q);
          end else if (timer_expire) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            err_q       <= 1'b1;
            result_q    <= ErrResult;
          end
        end

        StRead: begin
          // Shifting from zero leaves shorter results right-justified.
          result_q <= {result_q[15:0], mem_rdata};
          if (idx_q == res_bytes(prog_q) - 2'd1) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            mem_addr_q  <= '0;
          end else begin
            idx_q      <= idx_q + 2'd1;
            mem_addr_q <= mem_addr_q + 8'd1;
          end
        end

        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign start      = start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_prog   = prog_q;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_job_sequencer.sv
// Bench for job_sequencer: plays the compute engine and data memory, queues
// the expected response of every job it submits and compares on delivery.
module tb_job_sequencer;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned STARTC  = 2;

  typedef struct packed {
    logic [1:0]  prog;
    logic [23:0] res;
    logic        err;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_prog;
  logic [23:0] req_op;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        start;
  logic        done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_prog;
  logic [23:0] rsp_result;
  logic        rsp_err;

  logic [7:0]  mem [256];
  assign mem_rdata = mem[mem_addr];

  int n_vec;
  int n_err;

  rsp_t        exp_q[$];
  logic [15:0] exp_wr[$];
  logic [15:0] wr_obs[$];
  int          exp_nwr, exp_nrd;
  int          start_cnt, wait_cnt, lat, unstable;
  bit          got_rsp, post_ok;
  logic [23:0] got_res;
  logic        got_err;
  logic [1:0]  got_prog;

  job_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .START_CYCLES  (STARTC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_prog  (req_prog),
    .req_op    (req_op),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .start     (start),
    .done      (done),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_prog  (rsp_prog),
    .rsp_result(rsp_result),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Expected memory writes and response for one job; preloads the result
  // bytes the engine would have produced.
  task automatic build_exp(input logic [1:0] prog, input logic [23:0] op,
                           input logic [23:0] res, input bit to_err);
    rsp_t e;
    exp_wr.delete();
    e.res = 24'h0;
    case (prog)
      2'd1: begin
        exp_wr.push_back({8'd8, op[15:8]});
        exp_wr.push_back({8'd9, op[7:0]});
        mem[10] = res[15:8];
        mem[11] = res[7:0];
        exp_nwr = 2; exp_nrd = 2;
        e.res = {8'h00, res[15:0]};
      end
      2'd2: begin
        exp_wr.push_back({8'd0, op[23:16]});
        exp_wr.push_back({8'd1, op[15:8]});
        exp_wr.push_back({8'd2, op[7:0]});
        mem[4] = res[23:16];
        mem[5] = res[15:8];
        mem[6] = res[7:0];
        exp_nwr = 3; exp_nrd = 3;
        e.res = res;
      end
      2'd3: begin
        exp_wr.push_back({8'd13, op[15:8]});
        exp_wr.push_back({8'd14, op[7:0]});
        mem[15] = res[7:0];
        exp_nwr = 2; exp_nrd = 1;
        e.res = {16'h0000, res[7:0]};
      end
      default: begin
        exp_nwr = 0; exp_nrd = 0;
      end
    endcase
    e.prog = prog;
    e.err  = to_err || (prog == 2'd0);
    if (e.err) e.res = 24'hFFFFFF;
    exp_q.push_back(e);
  endtask

  // Submits one job and acts as the engine; records what the DUT did.
  task automatic drive_job(input logic [1:0] prog, input logic [23:0] op, input bit give_done,
                           input int done_dly, input bit spurious, input int hold);
    int c;
    bit saw_start;
    wr_obs.delete();
    start_cnt = 0; wait_cnt = 0; unstable = 0; lat = -1;
    got_rsp = 0; post_ok = 0; saw_start = 0;
    c = 0;
    @(negedge clk);
    while (!req_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    req_valid = 1'b1; req_prog = prog; req_op = op;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_prog = 2'd0; req_op = 24'h0;
    for (c = 1; c <= 200; c++) begin
      @(negedge clk);
      done = 1'b0;
      if (mem_we) wr_obs.push_back({mem_addr, mem_wdata});
      if (start) begin
        start_cnt++;
        saw_start = 1;
      end else if (saw_start && !rsp_valid) begin
        wait_cnt++;
        if (give_done && wait_cnt == done_dly + 1) done = 1'b1;
      end
      if (spurious && (mem_we || start)) done = 1'b1;
      if (rsp_valid) begin
        lat = c - 1;
        got_rsp = 1; got_res = rsp_result; got_err = rsp_err; got_prog = rsp_prog;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          if (!rsp_valid || rsp_result !== got_res || rsp_err !== got_err ||
              rsp_prog !== got_prog || req_ready) unstable++;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        post_ok = !rsp_valid && req_ready;
        break;
      end
    end
    done = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({start, mem_we, rsp_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ctrl: start/mem_we/rsp_valid got %b want 000", {start, mem_we, rsp_valid});
    end
    n_vec++;
    if ({rsp_result, rsp_prog, rsp_err} !== 27'h0) begin
      n_err++;
      $display("FAIL reset_rsp: result/prog/err got %h/%h/%b want 0", rsp_result, rsp_prog, rsp_err);
    end
    n_vec++;
    if ({mem_addr, mem_wdata} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_mem: addr/wdata got %h/%h want 0", mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: req_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_programs();
    logic [1:0] p;
    logic [23:0] op, res;
    rsp_t e;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin p = 2'd1; op = 24'h000003; res = 24'h002AAB; end
        1:       begin p = 2'd2; op = 24'h000103; res = 24'h005555; end
        default: begin p = 2'd3; op = 24'h00FFFF; res = 24'h0000FF; end
      endcase
      build_exp(p, op, res, 1'b0);
      drive_job(p, op, 1'b1, 0, 1'b0, 1);
      if (exp_q.size() != 0) e = exp_q.pop_front(); else e = '0;
      n_vec++;
      if (got_rsp !== 1'b1) begin
        n_err++;
        $display("FAIL prog%0d_rsp_seen: got %b want 1", p, got_rsp);
      end
      n_vec++;
      if ({got_prog, got_res, got_err} !== {e.prog, e.res, e.err}) begin
        n_err++;
        $display("FAIL prog%0d_rsp: got prog %0d res %h err %b want prog %0d res %h err %b",
                 p, got_prog, got_res, got_err, e.prog, e.res, e.err);
      end
      ok = (wr_obs.size() == exp_wr.size());
      if (ok) foreach (exp_wr[i]) if (wr_obs[i] !== exp_wr[i]) ok = 0;
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL prog%0d_writes: got %0d writes (first %h) want %0d (first %h)",
                 p, wr_obs.size(), (wr_obs.size() > 0) ? wr_obs[0] : 16'h0, exp_wr.size(), exp_wr[0]);
      end
      n_vec++;
      if (start_cnt != STARTC) begin
        n_err++;
        $display("FAIL prog%0d_start_width: got %0d cycles want %0d", p, start_cnt, STARTC);
      end
      n_vec++;
      if (lat != exp_nwr + STARTC + 1 + exp_nrd) begin
        n_err++;
        $display("FAIL prog%0d_latency: got %0d want %0d", p, lat, exp_nwr + STARTC + 1 + exp_nrd);
      end
      n_vec++;
      if (unstable != 0 || !post_ok) begin
        n_err++;
        $display("FAIL prog%0d_handshake: unstable %0d post_ok %b want 0/1", p, unstable, post_ok);
      end
    end
  endtask

  task automatic test_timeout();
    rsp_t e;
    build_exp(2'd3, 24'h00FFFF, 24'h000011, 1'b1);
    drive_job(2'd3, 24'h00FFFF, 1'b0, 0, 1'b0, 1);
    if (exp_q.size() != 0) e = exp_q.pop_front(); else e = '0;
    n_vec++;
    if (got_rsp !== 1'b1 || {got_prog, got_res, got_err} !== {e.prog, e.res, e.err}) begin
      n_err++;
      $display("FAIL timeout_rsp: seen %b prog %0d res %h err %b want prog %0d res %h err %b",
               got_rsp, got_prog, got_res, got_err, e.prog, e.res, e.err);
    end
    n_vec++;
    if (wait_cnt != TIMEOUT) begin
      n_err++;
      $display("FAIL timeout_wait_cycles: got %0d want %0d", wait_cnt, TIMEOUT);
    end
    n_vec++;
    if (lat != exp_nwr + STARTC + TIMEOUT) begin
      n_err++;
      $display("FAIL timeout_latency: got %0d want %0d", lat, exp_nwr + STARTC + TIMEOUT);
    end
  endtask

  task automatic test_illegal();
    rsp_t e;
    build_exp(2'd0, 24'h123456, 24'h0, 1'b0);
    drive_job(2'd0, 24'h123456, 1'b1, 0, 1'b0, 5);
    if (exp_q.size() != 0) e = exp_q.pop_front(); else e = '0;
    n_vec++;
    if (got_rsp !== 1'b1 || {got_prog, got_res, got_err} !== {e.prog, e.res, e.err}) begin
      n_err++;
      $display("FAIL illegal_rsp: seen %b prog %0d res %h err %b want prog %0d res %h err %b",
               got_rsp, got_prog, got_res, got_err, e.prog, e.res, e.err);
    end
    n_vec++;
    if (wr_obs.size() != 0 || start_cnt != 0) begin
      n_err++;
      $display("FAIL illegal_side_effects: writes %0d start cycles %0d want 0/0",
               wr_obs.size(), start_cnt);
    end
    n_vec++;
    if (lat != 0) begin
      n_err++;
      $display("FAIL illegal_latency: got %0d want 0", lat);
    end
    n_vec++;
    if (unstable != 0 || !post_ok) begin
      n_err++;
      $display("FAIL illegal_hold: unstable %0d post_ok %b want 0/1", unstable, post_ok);
    end
  endtask

  task automatic test_reset_mid_wait();
    int c;
    bit hit, seen;
    rsp_t e;
    // Round 0 resets while start is high, round 1 while waiting for done.
    for (int r = 0; r < 2; r++) begin
      c = 0;
      @(negedge clk);
      while (!req_ready && c < 50) begin
        @(negedge clk);
        c++;
      end
      req_valid = 1'b1; req_prog = 2'd1; req_op = 24'h000005;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      hit = 0; seen = 0;
      for (c = 0; c < 20 && !hit; c++) begin
        @(negedge clk);
        if (r == 0) hit = start;
        else if (start) seen = 1;
        else if (seen) hit = 1;
      end
      n_vec++;
      if (!hit) begin
        n_err++;
        $display("FAIL abort%0d_reach: target state not observed within 20 cycles", r);
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({start, mem_we, rsp_valid} !== 3'b000) begin
        n_err++;
        $display("FAIL abort%0d_outputs: start/mem_we/rsp_valid got %b want 000",
                 r, {start, mem_we, rsp_valid});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL abort%0d_release: req_ready %b rsp_valid %b want 1/0", r, req_ready, rsp_valid);
      end
    end
    build_exp(2'd1, 24'h000003, 24'h001234, 1'b0);
    drive_job(2'd1, 24'h000003, 1'b1, 1, 1'b0, 1);
    if (exp_q.size() != 0) e = exp_q.pop_front(); else e = '0;
    n_vec++;
    if (got_rsp !== 1'b1 || {got_prog, got_res, got_err} !== {e.prog, e.res, e.err}) begin
      n_err++;
      $display("FAIL post_abort_rsp: seen %b prog %0d res %h err %b want prog %0d res %h err %b",
               got_rsp, got_prog, got_res, got_err, e.prog, e.res, e.err);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] p;
    logic [23:0] op, res;
    int d, hold;
    bit sp, ok;
    rsp_t e;
    for (int k = 0; k < 8; k++) begin
      p    = 2'($urandom_range(1, 3));
      op   = 24'($urandom);
      res  = 24'($urandom);
      d    = int'($urandom_range(0, 3));
      sp   = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(0, 2));
      build_exp(p, op, res, 1'b0);
      drive_job(p, op, 1'b1, d, sp, hold);
      if (exp_q.size() != 0) e = exp_q.pop_front(); else e = '0;
      n_vec++;
      if (got_rsp !== 1'b1 || {got_prog, got_res, got_err} !== {e.prog, e.res, e.err}) begin
        n_err++;
        $display("FAIL b2b%0d_rsp: seen %b prog %0d res %h err %b want prog %0d res %h err %b",
                 k, got_rsp, got_prog, got_res, got_err, e.prog, e.res, e.err);
      end
      ok = (wr_obs.size() == exp_wr.size());
      if (ok) foreach (exp_wr[i]) if (wr_obs[i] !== exp_wr[i]) ok = 0;
      n_vec++;
      if (!ok || start_cnt != STARTC) begin
        n_err++;
        $display("FAIL b2b%0d_launch: writes ok %b start cycles %0d want 1/%0d",
                 k, ok, start_cnt, STARTC);
      end
      n_vec++;
      if (lat != exp_nwr + STARTC + 1 + d + exp_nrd || unstable != 0 || !post_ok) begin
        n_err++;
        $display("FAIL b2b%0d_timing: latency %0d unstable %0d post_ok %b want %0d/0/1",
                 k, lat, unstable, post_ok, exp_nwr + STARTC + 1 + d + exp_nrd);
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_prog = 2'd0; req_op = 24'h0;
    done = 1'b0; rsp_ready = 1'b0;
    foreach (mem[i]) mem[i] = 8'h00;
    test_reset();
    test_programs();
    test_timeout();
    test_illegal();
    test_reset_mid_wait();
    test_back_to_back();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d responses outstanding want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/job_sequencer.md
JOB_SEQUENCER -- requirements
Module: job_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum cycles to wait for done before aborting.
REQ-002 The block SHALL have parameter START_CYCLES, default 2: width of the start pulse in cycles.
REQ-003 Port clk  in  1  the single system clock; all state updates on its rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port req_valid  in  1  a job request is offered.
REQ-006 Port req_ready  out  1  the block accepts a request; high only in IDLE.
REQ-007 Port req_prog  in  2  program code: 1 = reciprocal, 2 = 16/8 divide, 3 = square root; 0 is illegal.
REQ-008 Port req_op  in  24  operands: prog1 divisor [15:0]; prog2 dividend [23:8], divisor [7:0]; prog3 operand [15:0].
REQ-009 Port mem_we  out  1  byte write strobe to the DUT data memory.
REQ-010 Port mem_addr  out  8  byte address into the data memory.
REQ-011 Port mem_wdata  out  8  write byte.
REQ-012 Port mem_rdata  in  8  combinational read data for mem_addr.
REQ-013 Port start  out  1  launch request to the DUT.
REQ-014 Port done  in  1  completion acknowledge from the DUT.
REQ-015 Port rsp_valid  out  1  a response is held.
REQ-016 Port rsp_ready  in  1  the consumer takes the response.
REQ-017 Port rsp_prog  out  2  program code of the response.
REQ-018 Port rsp_result  out  24  result, right-justified and zero-extended.
REQ-019 Port rsp_err  out  1  illegal program or timeout.

Function
REQ-020 FSM states: IDLE, WRITE, START, WAIT, READ, RESP.
REQ-021 IDLE -> WRITE on req_valid && req_ready, capturing req_prog and req_op; prog 0 goes IDLE -> RESP with rsp_err=1 and rsp_result=24'hFFFFFF.
REQ-022 WRITE writes one byte per cycle, MSB first: prog1 addresses 8,9; prog2 addresses 0,1,2; prog3 addresses 13,14.
REQ-023 START holds start=1 for exactly START_CYCLES cycles; mem_we=0 in this state.
REQ-024 WAIT samples done each cycle, starting the cycle after start falls; when done=1, WAIT -> READ.
REQ-025 The WAIT counter starts at 0; when it reaches TIMEOUT_CYCLES with done still 0, WAIT -> RESP with rsp_err=1 and rsp_result=24'hFFFFFF.
REQ-026 READ drives one address per cycle, MSB first, and captures mem_rdata in the same cycle: prog1 addresses 10,11; prog2 addresses 4,5,6; prog3 address 15.
REQ-027 Result widths: prog1 16 bits, prog2 24 bits, prog3 8 bits.
REQ-028 RESP holds rsp_valid=1 with stable rsp_prog, rsp_result and rsp_err until rsp_ready=1, then returns to IDLE.
REQ-029 req_ready is registered low in the cycle following acceptance.
REQ-030 Minimum latency for prog2, from the acceptance edge to rsp_valid: 3 (WRITE) + START_CYCLES + 1 (WAIT) + 3 (READ) cycles.
REQ-031 done=1 outside WAIT is ignored.
REQ-032 start=0 and mem_we=0 in every state except START and WRITE respectively.

Reset
REQ-033 While rst_n=0: FSM=IDLE; counters 0; start, mem_we and rsp_valid 0; rsp_result, rsp_prog and rsp_err 0; mem_addr and mem_wdata 0.
REQ-034 Reset in any state, including mid-WAIT, abandons the job with no response; req_ready=1 on the first edge after release.

Structure
REQ-035 Package job_seq_pkg SHALL hold the state enum, the program-code constants, and the per-program operand/result base addresses and byte counts.
REQ-036 The WAIT timeout counter SHALL be sub-module job_seq_timer (clear, enable, expire output), parameterised by TIMEOUT_CYCLES.

Verification
REQ-037 Prog1, req_op=0x000003; DUT model writes 0x2A,0xAB to addresses 10,11 and pulses done -> writes 0x00@8 and 0x03@9, start high 2 cycles, rsp_result=0x002AAB, rsp_err=0.
REQ-038 Prog2, req_op=0x000103 -> writes 0x00@0, 0x01@1, 0x03@2; model result 0x005555 -> reads 4,5,6, rsp_result=0x005555.
REQ-039 Prog3, req_op=0x00FFFF; model writes 0xFF@15 -> rsp_result=0x0000FF.
REQ-040 Prog3 with TIMEOUT_CYCLES=16 and done held 0 -> rsp_valid after 16 WAIT cycles, rsp_err=1, rsp_result=0xFFFFFF.
REQ-041 req_prog=0 -> no memory writes, start stays 0, rsp_err=1; rsp_ready held low 5 cycles -> response stable, then IDLE.
REQ-042 rst_n pulsed low mid-WAIT -> start, rsp_valid and mem_we immediately 0; a new prog1 job then completes correctly.
